// File: rtl/lzw_dict_ram_if.sv
// Access and clear-control bundle of the LZW dictionary RAM.
// The master drives requests; the slave (the RAM) returns read data and status.
interface lzw_dict_ram_if #(
    parameter int DATA_W = 13,
    parameter int ADDR_W = 12
);
    logic              en;
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic              err_access;

    modport master (
        output en, wren, addr, wr_data, clr_start,
        input  rd_data, rd_valid, clr_busy, clr_done, err_access
    );

    modport slave (
        input  en, wren, addr, wr_data, clr_start,
        output rd_data, rd_valid, clr_busy, clr_done, err_access
    );
endinterface

// File: rtl/lzw_dict_ram.sv
// Banked single-port LZW dictionary RAM, entries interleaved on the low address bits,
// with a clear sequencer that rewrites one row of every bank per cycle.
module lzw_dict_ram #(
    parameter int                 DATA_W    = 13,
    parameter int                 ADDR_W    = 12,
    parameter int                 NUM_BANKS = 4,
    parameter logic [DATA_W-1:0]  INIT_VAL  = '0
) (
    input  logic          clk,
    input  logic          rst,
    lzw_dict_ram_if.slave bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = ADDR_W - BANK_W;
    localparam int ROWS   = 2 ** ROW_W;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                clr_done_q, clr_done_d;
    logic                err_q, err_d;

    logic [BANK_W-1:0]   bank_sel;
    logic [ROW_W-1:0]    row;
    logic [DATA_W-1:0]   wdata;
    logic [NUM_BANKS-1:0] bank_we;
    logic [DATA_W-1:0]   bank_rd [NUM_BANKS];

    assign bank_sel = bus.addr[BANK_W-1:0];
    // The clear owns every bank's row and data path while it runs.
    assign row      = (state_q == CLEAR) ? cnt_q : bus.addr[ADDR_W-1:BANK_W];
    assign wdata    = (state_q == CLEAR) ? INIT_VAL : bus.wr_data;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [ROWS];

        // NOTE: RAM arrays carry no reset so they map onto memory macros; only control state is reset.
        always_ff @(posedge clk) begin
            if (bank_we[b]) mem[row] <= wdata;
        end

        assign bank_rd[b] = mem[row];
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch can be inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        clr_done_d = 1'b0;
        err_d      = 1'b0;
        bank_we    = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.clr_start) begin
                    state_d = CLEAR;
                    err_d   = bus.en;
                end else if (bus.en) begin
                    if (bus.wren) begin
                        bank_we[bank_sel] = 1'b1;
                    end else begin
                        rd_data_d  = bank_rd[bank_sel];
                        rd_valid_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                bank_we = '1;
                cnt_d   = cnt_q + ROW_W'(1);
                err_d   = bus.en;
                if (cnt_q == ROW_LAST) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            clr_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            clr_done_q <= clr_done_d;
            err_q      <= err_d;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.clr_busy   = (state_q == CLEAR);
    assign bus.clr_done   = clr_done_q;
    assign bus.err_access = err_q;
endmodule

// File: tb/tb_lzw_dict_ram.sv
// Directed bench for lzw_dict_ram: reset, read/write, full clear, dropped accesses, reset mid-clear.
module tb_lzw_dict_ram;
    localparam int DATA_W = 13;
    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    lzw_dict_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    lzw_dict_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(4), .INIT_VAL('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.en = 1'b0; bus.wren = 1'b0; bus.clr_start = 1'b0;
    endtask

    task automatic drive(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.en = 1'b1; bus.wren = wr; bus.addr = a; bus.wr_data = d; bus.clr_start = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        logic err_seen, rv_seen, dbg_busy;
        logic [DATA_W-1:0] vals [8];

        idle();
        bus.addr = '0; bus.wr_data = '0;

        // 1: reset
        repeat (3) step();
        chk("rst_rd_data", 16'(bus.rd_data), 16'h0);
        chk("rst_rd_valid", 16'(bus.rd_valid), 16'h0);
        chk("rst_busy", 16'(bus.clr_busy), 16'h0);
        chk("rst_done", 16'(bus.clr_done), 16'h0);
        chk("rst_err", 16'(bus.err_access), 16'h0);
        rst = 1'b0;
        step();

        // 2: single write then read
        drive(1'b1, 12'h005, 13'h1ABC);
        step();
        chk("wr_no_valid", 16'(bus.rd_valid), 16'h0);
        chk("wr_no_rd_data", 16'(bus.rd_data), 16'h0);
        drive(1'b0, 12'h005, 13'h0);
        step();
        chk("rd5_data", 16'(bus.rd_data), 16'h1ABC);
        chk("rd5_valid", 16'(bus.rd_valid), 16'h1);
        idle();
        step();
        chk("rd5_hold", 16'(bus.rd_data), 16'h1ABC);
        chk("rd5_valid_drop", 16'(bus.rd_valid), 16'h0);

        // 3: back-to-back writes across all banks, then reverse reads
        for (int i = 0; i < 8; i++) begin
            vals[i] = 13'(13'h100 + 13'(i * 37));
            drive(1'b1, 12'(i), vals[i]);
            step();
        end
        drive(1'b1, 12'h7FF, 13'h0AAA); step();
        drive(1'b1, 12'hFFF, 13'h1555); step();
        for (int i = 7; i >= 0; i--) begin
            drive(1'b0, 12'(i), 13'h0);
            step();
            chk($sformatf("b2b_rd%0d", i), 16'(bus.rd_data), 16'(vals[i]));
            chk($sformatf("b2b_v%0d", i), 16'(bus.rd_valid), 16'h1);
        end
        drive(1'b0, 12'hFFF, 13'h0); step();
        chk("pre_clr_fff", 16'(bus.rd_data), 16'h1555);

        // 4+5: clear started together with a read; later a read and a second clr_start mid-clear
        bus.en = 1'b1; bus.wren = 1'b0; bus.addr = 12'h005; bus.clr_start = 1'b1;
        step();
        chk("clr_busy_first", 16'(bus.clr_busy), 16'h1);
        chk("clr_start_err", 16'(bus.err_access), 16'h1);
        chk("clr_start_no_valid", 16'(bus.rd_valid), 16'h0);
        chk("clr_start_hold", 16'(bus.rd_data), 16'h1555);
        busy_cnt = 1; done_cnt = 0; err_seen = 1'b0; rv_seen = 1'b1;
        for (int k = 0; k < 1100; k++) begin
            idle();
            if (k == 100) begin
                bus.en = 1'b1; bus.wren = 1'b0; bus.addr = 12'h005; bus.clr_start = 1'b1;
            end
            step();
            if (bus.clr_done) done_cnt++;
            if (k == 100) begin
                err_seen = bus.err_access;
                rv_seen  = bus.rd_valid;
            end
            if (bus.clr_busy) busy_cnt++;
            else break;
        end
        chk("clr_len", 16'(busy_cnt), 16'd1024);
        chk("clr_done_at_end", 16'(bus.clr_done), 16'h1);
        chk("mid_clr_err", 16'(err_seen), 16'h1);
        chk("mid_clr_no_valid", 16'(rv_seen), 16'h0);
        chk("mid_clr_hold", 16'(bus.rd_data), 16'h1555);
        idle();
        step();
        if (bus.clr_done) done_cnt++;
        chk("clr_done_once", 16'(done_cnt), 16'd1);
        chk("clr_busy_after", 16'(bus.clr_busy), 16'h0);

        drive(1'b0, 12'h000, 13'h0); step();
        chk("cleared_000", 16'(bus.rd_data), 16'h0);
        drive(1'b0, 12'h7FF, 13'h0); step();
        chk("cleared_7ff", 16'(bus.rd_data), 16'h0);
        drive(1'b0, 12'hFFF, 13'h0); step();
        chk("cleared_fff", 16'(bus.rd_data), 16'h0);

        // wren without en does nothing
        bus.en = 1'b0; bus.wren = 1'b1; bus.addr = 12'h005; bus.wr_data = 13'h1FFF; bus.clr_start = 1'b0;
        step();
        chk("wren_no_en_valid", 16'(bus.rd_valid), 16'h0);
        drive(1'b0, 12'h005, 13'h0); step();
        chk("wren_no_en_nop", 16'(bus.rd_data), 16'h0);

        // 6: reset at clear cycle 500, then a full clear
        idle(); bus.clr_start = 1'b1;
        step();
        idle();
        done_cnt = 0;
        for (int k = 1; k < 500; k++) begin
            step();
            if (bus.clr_done) done_cnt++;
        end
        dbg_busy = bus.clr_busy;
        chk("busy_before_rst", 16'(dbg_busy), 16'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 16'(bus.clr_busy), 16'h0);
        step();
        rst = 1'b0;
        step();
        if (bus.clr_done) done_cnt++;
        step();
        if (bus.clr_done) done_cnt++;
        chk("rst_mid_no_done", 16'(done_cnt), 16'd0);

        bus.clr_start = 1'b1;
        step();
        idle();
        busy_cnt = bus.clr_busy ? 1 : 0;
        for (int k = 0; k < 1100 && bus.clr_busy; k++) begin
            step();
            if (bus.clr_busy) busy_cnt++;
        end
        chk("reclr_len", 16'(busy_cnt), 16'd1024);
        chk("reclr_done", 16'(bus.clr_done), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
